// File: rtl/regbank_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_wb_arbiter : round-robin write-back arbiter + pending-write scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regbank_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          rd_busy,
  output logic          stall,
  output logic          wr_en,
  output logic [AW-1:0] wr_rd,
  output logic [DW-1:0] wr_data,
  output logic          bad_rd
);

  localparam int NREG = 1 << AW;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  function automatic logic is_impl(input logic [AW-1:0] idx);
    return (int'(idx) <= 10) || ((int'(idx) >= 25) && (int'(idx) <= 31));
  endfunction

  src_e          last_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_rd_q;
  logic [DW-1:0] wr_data_q;
  logic          bad_q;
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] clrd_q;

  logic          hs_alu, hs_mem, hs;
  logic [AW-1:0] hs_rd;
  logic [DW-1:0] hs_data;
  logic          hs_impl;
  logic          bad_d;

  // Grant goes to the requester that did not win last, when both are valid.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      alu_ready = alu_valid & (~mem_valid | (last_q == SRC_MEM));
      mem_ready = mem_valid & (~alu_valid | (last_q == SRC_ALU));
    end
  end

  assign hs_alu  = alu_valid & alu_ready;
  assign hs_mem  = mem_valid & mem_ready;
  assign hs      = hs_alu | hs_mem;
  assign hs_rd   = hs_mem ? mem_rd : alu_rd;
  assign hs_data = hs_mem ? mem_data : alu_data;
  assign hs_impl = is_impl(hs_rd);
  assign bad_d   = bad_q | (hs & ~hs_impl) | (rsv_valid & ~is_impl(rsv_rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= SRC_ALU;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      bad_q     <= 1'b0;
    end else begin
      wr_en_q <= hs & hs_impl;
      bad_q   <= bad_d;
      if (hs) begin
        last_q <= hs_mem ? SRC_MEM : SRC_ALU;
      end
      if (hs & hs_impl) begin
        wr_rd_q   <= hs_rd;
        wr_data_q <= hs_data;
      end
    end
  end

  // Only implemented indices get a pending flop; clrd_q remembers a
  // clear from the previous cycle so stall covers the bank's write latency.
  for (genvar i = 0; i < NREG; i++) begin : g_sb
    if ((i <= 10) || ((i >= 25) && (i <= 31))) begin : g_impl
      logic p_q, p_d, c_q;
      assign p_d = (rsv_valid && (rsv_rd == AW'(i))) ||
                   (p_q && !(hs && (hs_rd == AW'(i))));
      always_ff @(posedge clk) begin
        if (rst) begin
          p_q <= 1'b0;
          c_q <= 1'b0;
        end else begin
          p_q <= p_d;
          c_q <= p_q & ~p_d;
        end
      end
      assign pend_q[i] = p_q;
      assign clrd_q[i] = c_q;
    end else begin : g_unimpl
      assign pend_q[i] = 1'b0;
      assign clrd_q[i] = 1'b0;
    end
  end

  assign rs_busy = pend_q[rs];
  assign rt_busy = pend_q[rt];
  assign rd_busy = pend_q[rd];
  assign stall   = rs_busy | rt_busy | rd_busy | clrd_q[rs] | clrd_q[rt] | clrd_q[rd];

  assign wr_en   = wr_en_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;
  assign bad_rd  = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_regbank_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regbank_wb_arbiter : directed and randomized checks against a reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regbank_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, rsv_valid;
  logic [4:0]  alu_rd, mem_rd, rsv_rd, rs, rt, rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, rs_busy, rt_busy, rd_busy, stall;
  logic        wr_en, bad_rd;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  int vectors = 0;
  int miscompares = 0;

  regbank_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .rs(rs), .rt(rt), .rd(rd),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .rd_busy(rd_busy), .stall(stall),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data), .bad_rd(bad_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit impl(input int idx);
    return (idx <= 10) || (idx >= 25 && idx <= 31);
  endfunction

  // Reference model: pending set, recently-cleared set, round-robin winner,
  // the write scheduled for the coming cycle, and the sticky error.
  bit          run_model = 0;
  bit          m_pend [32];
  bit          m_ext  [32];
  int          m_last = 0;
  bit          m_wr_en = 0;
  logic [4:0]  m_wr_rd = '0;
  logic [31:0] m_wr_data = '0;
  bit          m_bad = 0;
  bit          alu_acc = 0, mem_acc = 0;

  always @(negedge clk) begin
    if (run_model) begin
      int   grant;
      bit   nxt [32];
      logic [4:0] g_rd;
      logic [31:0] g_data;
      if (rst) grant = -1;
      else if (alu_valid && mem_valid) grant = (m_last == 0) ? 1 : 0;
      else if (alu_valid) grant = 0;
      else if (mem_valid) grant = 1;
      else grant = -1;

      chk("alu_ready", alu_ready, grant == 0);
      chk("mem_ready", mem_ready, grant == 1);
      chk("wr_en", wr_en, m_wr_en);
      if (m_wr_en) begin
        chk("wr_rd", wr_rd, m_wr_rd);
        chk("wr_data", wr_data, m_wr_data);
      end
      chk("bad_rd", bad_rd, m_bad);
      if (!rst) begin
        chk("rs_busy", rs_busy, m_pend[rs]);
        chk("rt_busy", rt_busy, m_pend[rt]);
        chk("rd_busy", rd_busy, m_pend[rd]);
        chk("stall", stall, m_pend[rs] | m_pend[rt] | m_pend[rd] |
                            m_ext[rs] | m_ext[rt] | m_ext[rd]);
      end
      alu_acc = alu_ready;
      mem_acc = mem_ready;

      if (rst) begin
        foreach (m_pend[i]) begin m_pend[i] = 0; m_ext[i] = 0; end
        m_last = 0; m_wr_en = 0; m_wr_rd = '0; m_wr_data = '0; m_bad = 0;
      end else begin
        g_rd   = (grant == 1) ? mem_rd : alu_rd;
        g_data = (grant == 1) ? mem_data : alu_data;
        m_wr_en = (grant >= 0) && impl(int'(g_rd));
        if (m_wr_en) begin m_wr_rd = g_rd; m_wr_data = g_data; end
        if (grant >= 0) begin
          m_last = grant;
          if (!impl(int'(g_rd))) m_bad = 1;
        end
        if (rsv_valid && !impl(int'(rsv_rd))) m_bad = 1;
        foreach (nxt[i]) nxt[i] = m_pend[i];
        if (m_wr_en) nxt[g_rd] = 0;
        if (rsv_valid && impl(int'(rsv_rd))) nxt[rsv_rd] = 1;
        foreach (nxt[i]) begin
          m_ext[i]  = m_pend[i] && !nxt[i];
          m_pend[i] = nxt[i];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] rnd_rd();
    int r;
    if ($urandom_range(0, 19) == 0) return 5'($urandom_range(11, 24));
    r = $urandom_range(0, 17);
    return (r <= 10) ? 5'(r) : 5'(r + 14);
  endfunction

  initial begin
    int order [4];
    int na, nm;
    bit g_mem;
    order = '{1, 0, 1, 0};
    foreach (m_pend[i]) begin m_pend[i] = 0; m_ext[i] = 0; end
    rst = 1'b1; alu_valid = 0; mem_valid = 0; rsv_valid = 0;
    alu_rd = '0; mem_rd = '0; rsv_rd = '0; rs = '0; rt = '0; rd = '0;
    alu_data = '0; mem_data = '0;

    @(posedge clk); run_model = 1;
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0); chk("rst_wr_rd", wr_rd, 0);
    chk("rst_wr_data", wr_data, 0); chk("rst_bad", bad_rd, 0);

    cyc(); rst = 0; rsv_valid = 1; rsv_rd = 5; rs = 5; rt = 6; rd = 15;
    @(negedge clk); chk("rsv_same_cycle_busy", rs_busy, 0);
    cyc(); rsv_valid = 0;
    @(negedge clk);
    chk("rsv_rs_busy", rs_busy, 1); chk("rsv_stall", stall, 1);
    chk("q6_busy", rt_busy, 0); chk("q15_busy", rd_busy, 0);

    cyc(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    @(negedge clk); chk("alu_alone_ready", alu_ready, 1);
    cyc(); alu_valid = 0;
    @(negedge clk);
    chk("alu_wr_en", wr_en, 1); chk("alu_wr_rd", wr_rd, 5);
    chk("alu_wr_data", wr_data, 32'hDEADBEEF);
    chk("alu_busy_drop", rs_busy, 0); chk("stall_ext", stall, 1);
    cyc();
    @(negedge clk); chk("stall_released", stall, 0); chk("wr_single", wr_en, 0);

    // Contention: both valid for four cycles, granted side advances its data.
    cyc(); na = 0; nm = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA0000000;
    mem_valid = 1; mem_rd = 2; mem_data = 32'hB0000000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_mem_grant", mem_ready, order[k] == 1);
      chk("rr_alu_grant", alu_ready, order[k] == 0);
      chk("rr_one_ready", alu_ready & mem_ready, 0);
      if (k > 0) chk("rr_wr_back2back", wr_en, 1);
      g_mem = mem_ready;
      cyc();
      if (g_mem) nm++; else na++;
      alu_data = 32'hA0000000 + 32'(na);
      mem_data = 32'hB0000000 + 32'(nm);
      if (k == 3) begin alu_valid = 0; mem_valid = 0; end
    end
    @(negedge clk);
    chk("rr_last_wr_en", wr_en, 1); chk("rr_last_rd", wr_rd, 1);
    chk("rr_last_data", wr_data, 32'hA0000001);

    cyc(); mem_valid = 1; mem_rd = 17; mem_data = 32'h12345678;
    @(negedge clk); chk("bad_mem_ready", mem_ready, 1);
    cyc(); mem_valid = 0;
    @(negedge clk); chk("bad_no_wr", wr_en, 0); chk("bad_set", bad_rd, 1);
    cyc(); rsv_valid = 1; rsv_rd = 20;
    @(negedge clk);
    cyc(); rsv_valid = 0; rs = 20;
    @(negedge clk); chk("bad_rsv_busy", rs_busy, 0); chk("bad_sticky", bad_rd, 1);

    cyc(); rsv_valid = 1; rsv_rd = 7;
    @(negedge clk);
    cyc(); alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    @(negedge clk); chk("setwin_ready", alu_ready, 1);
    cyc(); rsv_valid = 0; alu_valid = 0; rd = 7;
    @(negedge clk);
    chk("setwin_busy", rd_busy, 1); chk("setwin_wr_en", wr_en, 1); chk("setwin_wr_rd", wr_rd, 7);

    cyc(); rsv_valid = 1; rsv_rd = 3;
    @(negedge clk);
    cyc(); rsv_valid = 0; mem_valid = 1; mem_rd = 3; mem_data = 32'h33; rst = 1;
    @(negedge clk); chk("rst_mem_ready", mem_ready, 0); chk("rst_alu_ready", alu_ready, 0);
    cyc(); rst = 0; mem_valid = 0; rs = 3; rt = 7; rd = 5;
    @(negedge clk);
    chk("rst_drop_wr", wr_en, 0); chk("rst_rs_busy", rs_busy, 0);
    chk("rst_rt_busy", rt_busy, 0); chk("rst_bad_clr", bad_rd, 0); chk("rst_stall", stall, 0);

    // Randomized phase; requesters hold their request until accepted.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom_range(0, 99) < 60); alu_rd = rnd_rd(); alu_data = $urandom();
      end
      if (!mem_valid || mem_acc) begin
        mem_valid = ($urandom_range(0, 99) < 60); mem_rd = rnd_rd(); mem_data = $urandom();
      end
      rsv_valid = ($urandom_range(0, 99) < 30); rsv_rd = rnd_rd();
      rs = 5'($urandom()); rt = 5'($urandom()); rd = 5'($urandom());
      rst = ($urandom_range(0, 199) == 0);
    end
    cyc(); rst = 0; alu_valid = 0; mem_valid = 0; rsv_valid = 0;
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
